mem_access_arbiter: RTL

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

---
 rtl/mem_access_arbiter_if.sv | 43 ++++
 rtl/mem_access_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter_if.sv
// Bus bundle for mem_access_arbiter: core and host request ports, memory port, busy.
// slave = arbiter side, master = requesters/memory side.
interface mem_access_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              req_c;
   logic              req_h;
   logic              we_c;
   logic              we_h;
   logic [ADDR_W-1:0] addr_c;
   logic [ADDR_W-1:0] addr_h;
   logic [DATA_W-1:0] wdata_c;
   logic [DATA_W-1:0] wdata_h;
   logic [31:0]       key_c;
   logic [31:0]       key_h;
   logic              ack_c;
   logic              ack_h;
   logic              err_c;
   logic              err_h;
   logic [DATA_W-1:0] rdata_c;
   logic [DATA_W-1:0] rdata_h;
   logic              mem_re;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  req_c, req_h, we_c, we_h, addr_c, addr_h,
      input  wdata_c, wdata_h, key_c, key_h, mem_rdata,
      output ack_c, ack_h, err_c, err_h, rdata_c, rdata_h,
      output mem_re, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output req_c, req_h, we_c, we_h, addr_c, addr_h,
      output wdata_c, wdata_h, key_c, key_h, mem_rdata,
      input  ack_c, ack_h, err_c, err_h, rdata_c, rdata_h,
      input  mem_re, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-requester (core/host) memory arbiter with round-robin tie break and an
// optional key check on the protected region (macro MEM_SEC_CHECK_EN).
// Ports: clk, reset (async, active-high), bus (mem_access_arbiter_if.slave):
//   req/we/addr/wdata/key per requester in, ack/err/rdata per requester out,
//   mem_re/mem_we/mem_addr/mem_wdata out, mem_rdata in, busy out.
// All outputs are registered; ack is a one-cycle pulse in DONE.
module mem_access_arbiter #(
   parameter int                ADDR_W      = 8,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] SECURE_BASE = 8'hC0,
   parameter logic [31:0]       KEY         = 32'hA5A5_5A5A
) (
   input logic                 clk,
   input logic                 reset,
   mem_access_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]        state;
   // 1 = host was granted last, 0 = core
   logic              last_grant;
   logic              sel_host;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;

   logic              ack_c_q;
   logic              ack_h_q;
   logic [DATA_W-1:0] rdata_c_q;
   logic [DATA_W-1:0] rdata_h_q;
   logic              mem_re_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              busy_q;

   logic              any_req;
   logic              grant_host;
   logic              deny;

   // Host wins when it is alone, or on a tie when the core went last.
   always_comb begin
      any_req    = bus.req_c | bus.req_h;
      grant_host = bus.req_h & (~bus.req_c | ~last_grant);
   end

`ifdef MEM_SEC_CHECK_EN
   logic [31:0] lat_key;
   logic        err_c_q;
   logic        err_h_q;

   assign deny      = (lat_addr >= SECURE_BASE) && (lat_key != KEY);
   assign bus.err_c = err_c_q;
   assign bus.err_h = err_h_q;
`else
   logic unused_cfg;

   assign deny       = 1'b0;
   assign bus.err_c  = 1'b0;
   assign bus.err_h  = 1'b0;
   assign unused_cfg = ^{bus.key_c, bus.key_h, KEY, SECURE_BASE};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         sel_host    <= 1'b0;
         lat_we      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
`ifdef MEM_SEC_CHECK_EN
         lat_key     <= '0;
         err_c_q     <= 1'b0;
         err_h_q     <= 1'b0;
`endif
         ack_c_q     <= 1'b0;
         ack_h_q     <= 1'b0;
         rdata_c_q   <= '0;
         rdata_h_q   <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         // pulse outputs default low every cycle
         ack_c_q   <= 1'b0;
         ack_h_q   <= 1'b0;
         rdata_c_q <= '0;
         rdata_h_q <= '0;
         mem_re_q  <= 1'b0;
         mem_we_q  <= 1'b0;
`ifdef MEM_SEC_CHECK_EN
         err_c_q   <= 1'b0;
         err_h_q   <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  state      <= CHECK;
                  busy_q     <= 1'b1;
                  sel_host   <= grant_host;
                  last_grant <= grant_host;
                  lat_we     <= grant_host ? bus.we_h : bus.we_c;
                  lat_addr   <= grant_host ? bus.addr_h : bus.addr_c;
                  lat_wdata  <= grant_host ? bus.wdata_h : bus.wdata_c;
`ifdef MEM_SEC_CHECK_EN
                  lat_key    <= grant_host ? bus.key_h : bus.key_c;
`endif
               end
            end
            CHECK: begin
               if (deny) begin
                  // denied: skip ACCESS, ack one cycle early with err
                  state   <= DONE;
                  ack_c_q <= ~sel_host;
                  ack_h_q <= sel_host;
`ifdef MEM_SEC_CHECK_EN
                  err_c_q <= ~sel_host;
                  err_h_q <= sel_host;
`endif
               end else begin
                  state       <= ACCESS;
                  mem_re_q    <= ~lat_we;
                  mem_we_q    <= lat_we;
                  mem_addr_q  <= lat_addr;
                  mem_wdata_q <= lat_wdata;
               end
            end
            ACCESS: begin
               // mem_rdata is taken on the edge that closes the strobe
               // cycle so the registered rdata lines up with ack.
               state   <= DONE;
               ack_c_q <= ~sel_host;
               ack_h_q <= sel_host;
               if (!lat_we) begin
                  if (sel_host) begin
                     rdata_h_q <= bus.mem_rdata;
                  end else begin
                     rdata_c_q <= bus.mem_rdata;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ack_c     = ack_c_q;
   assign bus.ack_h     = ack_h_q;
   assign bus.rdata_c   = rdata_c_q;
   assign bus.rdata_h   = rdata_h_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;

endmodule
